// File: rtl/snoop_bus_ctrl.sv
// Snooping-bus transaction controller: round-robin arbitration of N_CPU cache
// requests, bus broadcast, snoop response collection, optional flush wait, ack.
module snoop_bus_ctrl #(
  parameter int unsigned N_CPU     = 3,
  parameter int unsigned TAG_W     = 3,
  parameter int unsigned SNOOP_LAT = 2,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned SRC_W    = $clog2(N_CPU)
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic [N_CPU-1:0]         req,
  input  logic [2*N_CPU-1:0]       req_op,
  input  logic [TAG_W*N_CPU-1:0]   req_tag,
  input  logic [N_CPU-1:0]         snoop_hit,
  input  logic [N_CPU-1:0]         snoop_dirty,
  input  logic                     flush_done,
  output logic [N_CPU-1:0]         grant,
  output logic                     bus_valid,
  output logic [1:0]               bus_op,
  output logic [TAG_W-1:0]         bus_tag,
  output logic [SRC_W-1:0]         bus_src,
  output logic [N_CPU-1:0]         snoop_en,
  output logic [N_CPU-1:0]         ack,
  output logic                     ack_shared,
  output logic                     err,
  output logic                     busy,
  output logic [CNT_W-1:0]         txn_count
);

  localparam int unsigned LAT_W = (SNOOP_LAT > 1) ? $clog2(SNOOP_LAT) : 1;
  localparam logic [1:0] OP_INV = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BCAST = 3'd1,
    SNOOP = 3'd2,
    FLUSH = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [SRC_W-1:0]   ptr, ptr_n;
  logic [SRC_W-1:0]   src, src_n;
  logic [1:0]         op, op_n;
  logic [TAG_W-1:0]   tag, tag_n;
  logic [LAT_W-1:0]   cnt, cnt_n;
  logic               shared, shared_n;

  logic [N_CPU-1:0]   grant_n, snoop_en_n, ack_n;
  logic               bus_valid_n, ack_shared_n, err_n, busy_n;
  logic [1:0]         bus_op_n;
  logic [TAG_W-1:0]   bus_tag_n;
  logic [SRC_W-1:0]   bus_src_n;
  logic [CNT_W-1:0]   txn_count_n;

  logic               found;
  logic [SRC_W-1:0]   win;
  logic [SRC_W-1:0]   cand;
  int unsigned        arb_idx;
  logic [1:0]         op_sel;
  logic [TAG_W-1:0]   tag_sel;
  logic               shared_now, dirty_now;

  // Round-robin search upward from ptr+1, wrapping modulo N_CPU
  always_comb begin
    found   = 1'b0;
    win     = '0;
    arb_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_CPU; k++) begin
      arb_idx = 32'(ptr) + k;
      if (arb_idx >= N_CPU) arb_idx = arb_idx - N_CPU;
      cand = SRC_W'(arb_idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    op_sel  = '0;
    tag_sel = '0;
    for (int unsigned i = 0; i < N_CPU; i++) begin
      if (win == SRC_W'(i)) begin
        op_sel  = req_op[2*i +: 2];
        tag_sel = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  // The requester's own snoop bits never count
  assign shared_now = |(snoop_hit & ~grant);
  assign dirty_now  = |(snoop_dirty & ~grant);

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    src_n        = src;
    op_n         = op;
    tag_n        = tag;
    cnt_n        = cnt;
    shared_n     = shared;
    grant_n      = grant;
    snoop_en_n   = snoop_en;
    bus_valid_n  = 1'b0;
    bus_op_n     = bus_op;
    bus_tag_n    = bus_tag;
    bus_src_n    = bus_src;
    ack_n        = '0;
    ack_shared_n = 1'b0;
    err_n        = 1'b0;
    txn_count_n  = txn_count;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_n      = BCAST;
          src_n        = win;
          op_n         = op_sel;
          tag_n        = tag_sel;
          grant_n      = '0;
          grant_n[win] = 1'b1;
          bus_valid_n  = 1'b1;
          bus_op_n     = op_sel;
          bus_tag_n    = tag_sel;
          bus_src_n    = win;
        end
      end
      BCAST: begin
        if (op == OP_RSV) begin
          state_n     = RESP;
          err_n       = 1'b1;
          shared_n    = 1'b0;
          ack_n       = grant;
          txn_count_n = txn_count + CNT_W'(1);
        end else begin
          state_n    = SNOOP;
          cnt_n      = LAT_W'(SNOOP_LAT - 1);
          snoop_en_n = ~grant;
        end
      end
      SNOOP: begin
        if (cnt == '0) begin
          shared_n = shared_now;
          if (dirty_now && (op != OP_INV)) begin
            state_n = FLUSH;
          end else begin
            state_n      = RESP;
            ack_n        = grant;
            ack_shared_n = shared_now;
            snoop_en_n   = '0;
            txn_count_n  = txn_count + CNT_W'(1);
          end
        end else begin
          cnt_n = cnt - LAT_W'(1);
        end
      end
      FLUSH: begin
        if (flush_done) begin
          state_n      = RESP;
          ack_n        = grant;
          ack_shared_n = shared;
          snoop_en_n   = '0;
          txn_count_n  = txn_count + CNT_W'(1);
        end
      end
      RESP: begin
        state_n = IDLE;
        grant_n = '0;
        ptr_n   = src;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // Outputs are registered copies of the values for the state being entered
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state      <= IDLE;
      ptr        <= SRC_W'(N_CPU - 1);
      src        <= '0;
      op         <= '0;
      tag        <= '0;
      cnt        <= '0;
      shared     <= 1'b0;
      grant      <= '0;
      bus_valid  <= 1'b0;
      bus_op     <= '0;
      bus_tag    <= '0;
      bus_src    <= '0;
      snoop_en   <= '0;
      ack        <= '0;
      ack_shared <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      txn_count  <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      src        <= src_n;
      op         <= op_n;
      tag        <= tag_n;
      cnt        <= cnt_n;
      shared     <= shared_n;
      grant      <= grant_n;
      bus_valid  <= bus_valid_n;
      bus_op     <= bus_op_n;
      bus_tag    <= bus_tag_n;
      bus_src    <= bus_src_n;
      snoop_en   <= snoop_en_n;
      ack        <= ack_n;
      ack_shared <= ack_shared_n;
      err        <= err_n;
      busy       <= busy_n;
      txn_count  <= txn_count_n;
    end
  end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed bench for snoop_bus_ctrl: a 3-CPU instance for protocol/timing and
// a 5-CPU, 6-bit-tag instance for width and round-robin wrap.
module tb_snoop_bus_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic clear_n;

  logic [2:0] req, snoop_hit, snoop_dirty, grant, snoop_en, ack;
  logic [5:0] req_op;
  logic [8:0] req_tag;
  logic       flush_done, bus_valid, ack_shared, err, busy;
  logic [1:0] bus_op, bus_src;
  logic [2:0] bus_tag;
  logic [15:0] txn_count;

  logic [4:0]  req5, hit5, dirty5, grant5, snoop_en5, ack5;
  logic [9:0]  req_op5;
  logic [29:0] req_tag5;
  logic        flush5, bus_valid5, ack_shared5, err5, busy5;
  logic [1:0]  bus_op5;
  logic [5:0]  bus_tag5;
  logic [2:0]  bus_src5;
  logic [15:0] txn_count5;

  snoop_bus_ctrl u_dut (
    .clock(clock), .clear_n(clear_n), .req(req), .req_op(req_op), .req_tag(req_tag),
    .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty), .flush_done(flush_done),
    .grant(grant), .bus_valid(bus_valid), .bus_op(bus_op), .bus_tag(bus_tag),
    .bus_src(bus_src), .snoop_en(snoop_en), .ack(ack), .ack_shared(ack_shared),
    .err(err), .busy(busy), .txn_count(txn_count)
  );

  snoop_bus_ctrl #(.N_CPU(5), .TAG_W(6), .SNOOP_LAT(2), .CNT_W(16)) u_dut5 (
    .clock(clock), .clear_n(clear_n), .req(req5), .req_op(req_op5), .req_tag(req_tag5),
    .snoop_hit(hit5), .snoop_dirty(dirty5), .flush_done(flush5),
    .grant(grant5), .bus_valid(bus_valid5), .bus_op(bus_op5), .bus_tag(bus_tag5),
    .bus_src(bus_src5), .snoop_en(snoop_en5), .ack(ack5), .ack_shared(ack_shared5),
    .err(err5), .busy(busy5), .txn_count(txn_count5)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_txn = 0;
  int n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int cnt);
    repeat (cnt) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic seen(input int sel);
    case (sel)
      0:       return |grant;
      1:       return |ack;
      2:       return |grant5;
      default: return |ack5;
    endcase
  endfunction

  // Poll a grant/ack bus with a cycle budget; returns cycles waited
  task automatic wait_for(input int sel, input string tag, output int waited);
    waited = 0;
    while (!seen(sel) && waited < 50) begin
      cyc(1);
      waited++;
    end
    if (waited >= 50) check({tag, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic issue(input int cpu, input logic [1:0] op, input logic [2:0] tag);
    req[cpu]            = 1'b1;
    req_op[2*cpu +: 2]  = op;
    req_tag[3*cpu +: 3] = tag;
  endtask

  task automatic issue5(input int cpu, input logic [5:0] tag);
    req5[cpu]            = 1'b1;
    req_op5[2*cpu +: 2]  = 2'b00;
    req_tag5[6*cpu +: 6] = tag;
  endtask

  logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    clear_n = 1'b0;
    req = '0; req_op = '0; req_tag = '0; snoop_hit = '0; snoop_dirty = '0; flush_done = 1'b0;
    req5 = '0; req_op5 = '0; req_tag5 = '0; hit5 = '0; dirty5 = '0; flush5 = 1'b0;
    cyc(2);
    check("rst grant", 32'(grant), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst txn", 32'(txn_count), 32'd0);
    check("rst bus_valid", 32'(bus_valid), 32'd0);
    clear_n = 1'b1;
    cyc(1);

    // CPU1 read miss, CPU2 holds the block
    snoop_hit = 3'b100;
    issue(1, 2'b00, 3'b101);
    cyc(1);
    check("t1 grant", 32'(grant), 32'b010);
    check("t1 bus_valid", 32'(bus_valid), 32'd1);
    check("t1 bus_op", 32'(bus_op), 32'd0);
    check("t1 bus_tag", 32'(bus_tag), 32'b101);
    check("t1 bus_src", 32'(bus_src), 32'd1);
    cyc(1);
    check("t1 snoop_en", 32'(snoop_en), 32'b101);
    check("t1 bus_valid drop", 32'(bus_valid), 32'd0);
    cyc(2);
    check("t1 ack", 32'(ack), 32'b010);
    check("t1 ack_shared", 32'(ack_shared), 32'd1);
    check("t1 txn", 32'(txn_count), 32'd1);
    req = '0;
    cyc(1);
    check("t1 grant clear", 32'(grant), 32'd0);
    check("t1 idle", 32'(busy), 32'd0);

    // All three request; round-robin order from reset, CPU0 re-requests
    clear_n = 1'b0; cyc(1); clear_n = 1'b1;
    exp_txn = 0;
    snoop_hit = '0;
    issue(0, 2'b00, 3'd1); issue(1, 2'b00, 3'd2); issue(2, 2'b00, 3'd3);
    for (int i = 0; i < 4; i++) begin
      wait_for(0, "rr grant", n);
      check("rr grant", 32'(grant), 32'(rr_exp[i]));
      wait_for(1, "rr ack", n);
      check("rr ack", 32'(ack), 32'(rr_exp[i]));
      exp_txn++;
      req = req & ~rr_exp[i];
      if (i == 2) req[0] = 1'b1;
      cyc(1);
    end
    check("rr txn", 32'(txn_count), 32'(exp_txn));

    // CPU0 write miss with a dirty owner -> flush wait
    snoop_dirty = 3'b010; snoop_hit = 3'b010;
    issue(0, 2'b01, 3'b110);
    wait_for(0, "fl grant", n);
    check("fl grant", 32'(grant), 32'b001);
    check("fl bus_op", 32'(bus_op), 32'b01);
    cyc(3);
    check("fl no ack", 32'(ack), 32'd0);
    check("fl snoop_en", 32'(snoop_en), 32'b110);
    check("fl busy", 32'(busy), 32'd1);
    cyc(4);
    check("fl still waiting", 32'(ack), 32'd0);
    flush_done = 1'b1;
    cyc(1);
    flush_done = 1'b0;
    check("fl ack", 32'(ack), 32'b001);
    check("fl ack_shared", 32'(ack_shared), 32'd1);
    exp_txn++;
    req = '0; snoop_dirty = '0; snoop_hit = '0;
    cyc(1);

    // CPU2 invalidate with dirty reported: no flush, fixed latency
    snoop_dirty = 3'b001; snoop_hit = 3'b001;
    issue(2, 2'b10, 3'b011);
    wait_for(0, "inv grant", n);
    check("inv grant", 32'(grant), 32'b100);
    wait_for(1, "inv ack", n);
    check("inv latency", 32'(n), 32'd3);
    check("inv ack", 32'(ack), 32'b100);
    check("inv ack_shared", 32'(ack_shared), 32'd1);
    exp_txn++;
    req = '0; snoop_dirty = '0; snoop_hit = '0;
    cyc(1);

    // Requester's own hit is masked
    snoop_hit = 3'b010;
    issue(1, 2'b00, 3'b001);
    wait_for(0, "own grant", n);
    check("own grant", 32'(grant), 32'b010);
    wait_for(1, "own ack", n);
    check("own ack", 32'(ack), 32'b010);
    check("own ack_shared", 32'(ack_shared), 32'd0);
    exp_txn++;
    req = '0;
    cyc(1);

    // Reserved opcode: err with ack, no snoop phase
    snoop_hit = 3'b110;
    issue(0, 2'b11, 3'b111);
    wait_for(0, "rsv grant", n);
    check("rsv grant", 32'(grant), 32'b001);
    cyc(1);
    check("rsv err", 32'(err), 32'd1);
    check("rsv ack", 32'(ack), 32'b001);
    check("rsv ack_shared", 32'(ack_shared), 32'd0);
    check("rsv snoop_en", 32'(snoop_en), 32'd0);
    exp_txn++;
    req = '0; snoop_hit = '0;
    cyc(1);
    check("rsv err pulse", 32'(err), 32'd0);
    check("rsv txn", 32'(txn_count), 32'(exp_txn));

    // Reset in SNOOP aborts; CPU0 then wins first
    issue(1, 2'b00, 3'b010);
    wait_for(0, "ab grant", n);
    check("ab grant", 32'(grant), 32'b010);
    cyc(1);
    check("ab snoop_en", 32'(snoop_en), 32'b101);
    clear_n = 1'b0;
    cyc(1);
    check("ab grant", 32'(grant), 32'd0);
    check("ab snoop_en0", 32'(snoop_en), 32'd0);
    check("ab busy", 32'(busy), 32'd0);
    check("ab ack", 32'(ack), 32'd0);
    check("ab txn", 32'(txn_count), 32'd0);
    clear_n = 1'b1;
    issue(0, 2'b00, 3'b100);
    wait_for(0, "ab2 grant", n);
    check("ab2 grant", 32'(grant), 32'b001);
    wait_for(1, "ab2 ack", n);
    check("ab2 ack", 32'(ack), 32'b001);
    req[0] = 1'b0;
    cyc(1);
    wait_for(0, "ab3 grant", n);
    check("ab3 grant", 32'(grant), 32'b010);
    wait_for(1, "ab3 ack", n);
    check("ab3 ack", 32'(ack), 32'b010);
    req = '0;
    cyc(1);
    check("ab txn2", 32'(txn_count), 32'd2);

    // 5-CPU instance: wide tags and pointer wrap
    issue5(0, 6'h15); issue5(4, 6'h2a);
    wait_for(2, "w grant0", n);
    check("w grant0", 32'(grant5), 32'b00001);
    check("w tag0", 32'(bus_tag5), 32'h15);
    check("w src0", 32'(bus_src5), 32'd0);
    wait_for(3, "w ack0", n);
    check("w ack0", 32'(ack5), 32'b00001);
    req5[0] = 1'b0;
    cyc(1);
    wait_for(2, "w grant4", n);
    check("w grant4", 32'(grant5), 32'b10000);
    check("w tag4", 32'(bus_tag5), 32'h2a);
    check("w src4", 32'(bus_src5), 32'd4);
    wait_for(3, "w ack4", n);
    req5[4] = 1'b0;
    issue5(0, 6'h01); issue5(3, 6'h3f);
    cyc(1);
    wait_for(2, "w wrap", n);
    check("w wrap", 32'(grant5), 32'b00001);
    wait_for(3, "w ack wrap", n);
    req5[0] = 1'b0;
    cyc(1);
    wait_for(2, "w grant3", n);
    check("w grant3", 32'(grant5), 32'b01000);
    check("w tag3", 32'(bus_tag5), 32'h3f);
    wait_for(3, "w ack3", n);
    check("w ack3", 32'(ack5), 32'b01000);
    req5 = '0;
    cyc(1);
    check("w txn", 32'(txn_count5), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
